// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, opcode constants, legal-opcode table, FSM states.
package alu_pkg;

    localparam int ALU_W    = 16;
    localparam int ALU_OP_W = 6;

    // Opcode bit k enables, in order: zx, nx, zy, ny, f (add/and), no
    localparam logic [ALU_OP_W-1:0] ALU_OP_ZERO     = 6'b010101;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ONE      = 6'b111111;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NEG1     = 6'b010111;
    localparam logic [ALU_OP_W-1:0] ALU_OP_X        = 6'b001100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_Y        = 6'b000011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOT_X    = 6'b101100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOT_Y    = 6'b100011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NEG_X    = 6'b111100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NEG_Y    = 6'b110011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_X_PLUS1  = 6'b111110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_Y_PLUS1  = 6'b111011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_X_MINUS1 = 6'b011100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_Y_MINUS1 = 6'b010011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD      = 6'b010000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_X_SUB_Y  = 6'b110010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_Y_SUB_X  = 6'b111000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND      = 6'b000000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR       = 6'b101010;

    localparam int ALU_NUM_LEGAL = 18;

    localparam logic [ALU_OP_W-1:0] ALU_LEGAL_OPS [ALU_NUM_LEGAL] = '{
        ALU_OP_ZERO, ALU_OP_ONE, ALU_OP_NEG1, ALU_OP_X, ALU_OP_Y,
        ALU_OP_NOT_X, ALU_OP_NOT_Y, ALU_OP_NEG_X, ALU_OP_NEG_Y,
        ALU_OP_X_PLUS1, ALU_OP_Y_PLUS1, ALU_OP_X_MINUS1, ALU_OP_Y_MINUS1,
        ALU_OP_ADD, ALU_OP_X_SUB_Y, ALU_OP_Y_SUB_X, ALU_OP_AND, ALU_OP_OR
    };

    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < ALU_NUM_LEGAL; i++) begin
            if (op == ALU_LEGAL_OPS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OP_W
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req_x0;
    logic [W-1:0]   req_y0;
    logic [W-1:0]   req_x1;
    logic [W-1:0]   req_y1;
    logic [OPW-1:0] req_op0;
    logic [OPW-1:0] req_op1;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [W-1:0]   rsp_out;
    logic           rsp_zr;
    logic           rsp_ng;
    logic           rsp_err;

    modport slave (
        input  req_valid, req_x0, req_y0, req_x1, req_y1, req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_zr, rsp_ng, rsp_err
    );

    modport master (
        output req_valid, req_x0, req_y0, req_x1, req_y1, req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_zr, rsp_ng, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Existing combinational ALU: conditional zero/negate on each operand, add or and, optional negate of result.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0]        x,
    input  logic [W-1:0]        y,
    input  logic [ALU_OP_W-1:0] op,
    output logic [W-1:0]        out,
    output logic                zr,
    output logic                ng
);
    logic [W-1:0] xa, xb, ya, yb, fo;

    always_comb begin
        xa  = op[0] ? '0 : x;
        xb  = op[1] ? ~xa : xa;
        ya  = op[2] ? '0 : y;
        yb  = op[3] ? ~ya : ya;
        fo  = op[4] ? (xb + yb) : (xb & yb);
        out = op[5] ? ~fo : fo;
        zr  = (out == '0);
        ng  = out[W-1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one transaction in flight.
// Define ALU_ARB_OPCHECK_EN to flag illegal opcodes on rsp_err instead of passing them to the ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OP_W
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    arb_state_t     state_q, state_d;
    logic           last_grant_q;
    logic           win_q;
    logic [W-1:0]   x_q, y_q;
    logic [OPW-1:0] op_q;
    logic [W-1:0]   out_q;
    logic           zr_q, ng_q;

    logic           accept, capture, grant;
    logic [1:0]     req_ready, rsp_valid;
    logic [W-1:0]   alu_out;
    logic           alu_zr, alu_ng;

    alu #(.W(W)) u_alu (
        .x   (x_q),
        .y   (y_q),
        .op  (op_q),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        grant     = 1'b0;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    // On a tie the requester that did not win last time goes first
                    grant            = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
                    accept           = 1'b1;
                    req_ready[grant] = 1'b1;
                    state_d          = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[win_q] = 1'b1;
                if (bus.rsp_ready[win_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            op_q         <= '0;
        end else if (accept) begin
            last_grant_q <= grant;
            win_q        <= grant;
            x_q          <= grant ? bus.req_x1  : bus.req_x0;
            y_q          <= grant ? bus.req_y1  : bus.req_y0;
            op_q         <= grant ? bus.req_op1 : bus.req_op0;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (capture) begin
            if (alu_op_legal(op_q)) begin
                out_q <= alu_out;
                zr_q  <= alu_zr;
                ng_q  <= alu_ng;
                err_q <= 1'b0;
            end else begin
                out_q <= '0;
                zr_q  <= 1'b0;
                ng_q  <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
        end else if (capture) begin
            out_q <= alu_out;
            zr_q  <= alu_zr;
            ng_q  <= alu_ng;
        end
    end

    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_out   = out_q;
    assign bus.rsp_zr    = zr_q;
    assign bus.rsp_ng    = ng_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: randomized traffic against an arithmetic reference model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic m_last;

    alu_arbiter_if #(.W(16), .OPW(6)) bus ();

    alu_arbiter #(.W(16), .OPW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU in terms of what each named opcode computes
    function automatic void model_alu(input logic [5:0] op, input logic [15:0] x, input logic [15:0] y,
                                      output logic [15:0] res, output logic legal);
        legal = 1'b1;
        case (op)
            ALU_OP_ZERO:     res = 16'd0;
            ALU_OP_ONE:      res = 16'd1;
            ALU_OP_NEG1:     res = 16'hFFFF;
            ALU_OP_X:        res = x;
            ALU_OP_Y:        res = y;
            ALU_OP_NOT_X:    res = ~x;
            ALU_OP_NOT_Y:    res = ~y;
            ALU_OP_NEG_X:    res = 16'd0 - x;
            ALU_OP_NEG_Y:    res = 16'd0 - y;
            ALU_OP_X_PLUS1:  res = x + 16'd1;
            ALU_OP_Y_PLUS1:  res = y + 16'd1;
            ALU_OP_X_MINUS1: res = x - 16'd1;
            ALU_OP_Y_MINUS1: res = y - 16'd1;
            ALU_OP_ADD:      res = x + y;
            ALU_OP_X_SUB_Y:  res = x - y;
            ALU_OP_Y_SUB_X:  res = y - x;
            ALU_OP_AND:      res = x & y;
            ALU_OP_OR:       res = x | y;
            default: begin
                res   = 16'd0;
                legal = 1'b0;
            end
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [18];
        ops = '{ALU_OP_ZERO, ALU_OP_ONE, ALU_OP_NEG1, ALU_OP_X, ALU_OP_Y, ALU_OP_NOT_X,
                ALU_OP_NOT_Y, ALU_OP_NEG_X, ALU_OP_NEG_Y, ALU_OP_X_PLUS1, ALU_OP_Y_PLUS1,
                ALU_OP_X_MINUS1, ALU_OP_Y_MINUS1, ALU_OP_ADD, ALU_OP_X_SUB_Y, ALU_OP_Y_SUB_X,
                ALU_OP_AND, ALU_OP_OR};
        return ops[$urandom_range(0, 17)];
    endfunction

    // Runs one full transaction starting in IDLE at posedge+1; returns at posedge+1 back in IDLE.
    task automatic do_txn(input logic [1:0] vld, input logic [15:0] x0, input logic [15:0] y0,
                          input logic [5:0] op0, input logic [15:0] x1, input logic [15:0] y1,
                          input logic [5:0] op1, input int hold);
        logic        w;
        logic [15:0] ex, xs, ys;
        logic [5:0]  os;
        logic        legal, ezr, eng, eerr, chk_data;
        w      = (vld == 2'b11) ? ~m_last : vld[1];
        m_last = w;
        xs = w ? x1 : x0;
        ys = w ? y1 : y0;
        os = w ? op1 : op0;
        model_alu(os, xs, ys, ex, legal);
        chk_data = 1'b1;
        eerr     = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
        if (!legal) begin
            ex   = 16'd0;
            eerr = 1'b1;
        end
`else
        if (!legal) chk_data = 1'b0;
`endif
        ezr = (ex == 16'd0) && !eerr;
        eng = ex[15];

        bus.req_x0 = x0; bus.req_y0 = y0; bus.req_op0 = op0;
        bus.req_x1 = x1; bus.req_y1 = y1; bus.req_op1 = op1;
        bus.req_valid = vld;
        bus.rsp_ready = 2'b00;
        #1;
        n_tests++;
        if (bus.req_ready !== (2'b01 << w)) begin
            n_fail++;
            $display("FAIL grant got=%b exp=%b vld=%b", bus.req_ready, 2'b01 << w, vld);
        end

        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        bus.req_x0 = 16'($urandom); bus.req_y0 = 16'($urandom); bus.req_op0 = 6'($urandom);
        bus.req_x1 = 16'($urandom); bus.req_y1 = 16'($urandom); bus.req_op1 = 6'($urandom);
        #1;
        n_tests++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL exec_quiet got ready=%b valid=%b exp=00/00", bus.req_ready, bus.rsp_valid);
        end

        @(posedge clk); #1;
        n_tests++;
        if (bus.rsp_valid !== (2'b01 << w) || bus.rsp_err !== eerr) begin
            n_fail++;
            $display("FAIL resp_valid got valid=%b err=%b exp=%b/%b", bus.rsp_valid, bus.rsp_err, 2'b01 << w, eerr);
        end
        if (chk_data) begin
            n_tests++;
            if (bus.rsp_out !== ex || bus.rsp_zr !== ezr || bus.rsp_ng !== eng) begin
                n_fail++;
                $display("FAIL result op=%b x=%h y=%h got=%h zr=%b ng=%b exp=%h zr=%b ng=%b",
                         os, xs, ys, bus.rsp_out, bus.rsp_zr, bus.rsp_ng, ex, ezr, eng);
            end
        end

        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 2'b01 << (~w);
            bus.req_valid = 2'($urandom_range(0, 3));
            #1;
            n_tests++;
            if (bus.req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL busy_ready got=%b exp=00 cycle=%0d", bus.req_ready, i);
            end
            @(posedge clk); #1;
            n_tests++;
            if (bus.rsp_valid !== (2'b01 << w) || (chk_data && bus.rsp_out !== ex)) begin
                n_fail++;
                $display("FAIL hold got valid=%b out=%h exp=%b/%h cycle=%0d", bus.rsp_valid, bus.rsp_out, 2'b01 << w, ex, i);
            end
        end

        bus.req_valid = 2'b00;
        bus.rsp_ready = (2'b01 << w) | 2'($urandom_range(0, 3));
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        n_tests++;
        if (bus.rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL release got=%b exp=00", bus.rsp_valid);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_out !== 16'd0 ||
            bus.rsp_zr !== 1'b0 || bus.rsp_ng !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got rdy=%b vld=%b out=%h zr=%b ng=%b err=%b exp=all zero",
                     bus.req_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_zr, bus.rsp_ng, bus.rsp_err);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_txn(2'b01, 16'd5, 16'd0, ALU_OP_X, 16'd0, 16'd0, ALU_OP_ZERO, 0);
    endtask

    task automatic test_flags();
        do_txn(2'b01, 16'h1234, 16'h4321, ALU_OP_ZERO, 16'd0, 16'd0, ALU_OP_ZERO, 0);
        do_txn(2'b10, 16'd0, 16'd0, ALU_OP_ZERO, 16'h0F0F, 16'h00FF, ALU_OP_NEG1, 0);
        do_txn(2'b01, 16'h8000, 16'h0001, ALU_OP_ONE, 16'd0, 16'd0, ALU_OP_ZERO, 0);
    endtask

    task automatic test_round_robin();
        apply_reset();
        do_txn(2'b11, 16'd1, 16'd2, ALU_OP_ADD, 16'd7, 16'd3, ALU_OP_X_SUB_Y, 0);
        do_txn(2'b11, 16'd1, 16'd2, ALU_OP_ADD, 16'd7, 16'd3, ALU_OP_X_SUB_Y, 0);
        do_txn(2'b11, 16'd9, 16'd4, ALU_OP_Y_SUB_X, 16'd7, 16'd3, ALU_OP_OR, 0);
        do_txn(2'b10, 16'd0, 16'd0, ALU_OP_ZERO, 16'hAAAA, 16'h5555, ALU_OP_AND, 0);
        do_txn(2'b11, 16'hFFFF, 16'd1, ALU_OP_ADD, 16'd7, 16'd3, ALU_OP_ADD, 0);
    endtask

    task automatic test_backpressure();
        do_txn(2'b10, 16'd0, 16'd0, ALU_OP_ZERO, 16'h7FFF, 16'd1, ALU_OP_ADD, 10);
        do_txn(2'b11, 16'h0003, 16'h0005, ALU_OP_NEG_X, 16'd2, 16'd2, ALU_OP_ADD, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            do_txn(2'($urandom_range(1, 3)),
                   16'($urandom), 16'($urandom), rand_op(),
                   16'($urandom), 16'($urandom), rand_op(),
                   int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_exec();
        bus.req_x0 = 16'h00AA; bus.req_y0 = 16'd0; bus.req_op0 = ALU_OP_X;
        bus.req_valid = 2'b01;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_out !== 16'd0 ||
            bus.rsp_zr !== 1'b0 || bus.rsp_ng !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_exec got rdy=%b vld=%b out=%h zr=%b ng=%b err=%b exp=all zero",
                     bus.req_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_zr, bus.rsp_ng, bus.rsp_err);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.rsp_valid !== 2'b00 || bus.rsp_out !== 16'd0) begin
                n_fail++;
                $display("FAIL no_resp_after_reset got vld=%b out=%h exp=00/0000", bus.rsp_valid, bus.rsp_out);
            end
        end
        do_txn(2'b11, 16'd3, 16'd4, ALU_OP_ADD, 16'd5, 16'd6, ALU_OP_ADD, 0);
    endtask

    task automatic test_opcheck();
        do_txn(2'b01, 16'h1234, 16'h5678, 6'b100000, 16'd0, 16'd0, ALU_OP_ZERO, 1);
        do_txn(2'b10, 16'd0, 16'd0, ALU_OP_ZERO, 16'h1111, 16'h2222, 6'b000001, 0);
        do_txn(2'b01, 16'h0011, 16'h0022, ALU_OP_ADD, 16'd0, 16'd0, ALU_OP_ZERO, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_last  = 1'b1;
        rst_n   = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_x0 = '0; bus.req_y0 = '0; bus.req_op0 = '0;
        bus.req_x1 = '0; bus.req_y1 = '0; bus.req_op1 = '0;

        test_reset();
        test_basic();
        test_flags();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_exec();
        test_opcheck();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
